// File: rtl/lut_layer_pkg.sv
// Shared definitions for the time-multiplexed LogicNets layer: geometry, FSM
// states, connectivity map, trained truth tables and table-address helpers.
package lut_layer_pkg;

    localparam int N_IN   = 8;
    localparam int N_NEUR = 16;
    localparam int FANIN  = 2;
    localparam int BW     = 2;

    function automatic int neur_width();
        return $clog2(N_NEUR);
    endfunction

    function automatic int idx_width();
        return FANIN * BW;
    endfunction

    function automatic int addr_width();
        return neur_width() + idx_width();
    endfunction

    localparam int NEUR_W = neur_width();
    localparam int IDX_W  = idx_width();
    localparam int ADDR_W = addr_width();
    localparam int TT_W   = (1 << IDX_W) * BW;
    localparam logic [NEUR_W-1:0] LAST_NEUR = NEUR_W'(N_NEUR - 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // CONN[n][k] is the input activation feeding fan-in slot k of neuron n.
    localparam int CONN [N_NEUR][FANIN] = '{
        '{0, 3}, '{1, 4}, '{2, 5}, '{3, 6}, '{4, 7}, '{5, 0}, '{6, 1}, '{7, 2},
        '{0, 5}, '{1, 6}, '{2, 7}, '{3, 0}, '{4, 1}, '{5, 2}, '{6, 3}, '{7, 4}
    };

    // Trained truth tables, one packed word per neuron; entry i sits at [i*BW +: BW].
    localparam logic [TT_W-1:0] TT_INIT [N_NEUR] = '{
        32'hE4E4_1B1B, 32'h9C63_A5F0, 32'h0FF0_3CC3, 32'h5A5A_C936,
        32'h7E81_24DB, 32'hB4D2_6A95, 32'h1234_5678, 32'h89AB_CDEF,
        32'hF00F_55AA, 32'h3C96_E1A7, 32'hD2B4_8E71, 32'h6969_9696,
        32'hA0B1_C2D3, 32'h4E2D_7B18, 32'hC3A5_5AC3, 32'h2F4B_87E1
    };

    function automatic logic [BW-1:0] rom_entry(input logic [ADDR_W-1:0] addr);
        return TT_INIT[addr[ADDR_W-1 -: NEUR_W]][addr[IDX_W-1:0] * BW +: BW];
    endfunction

endpackage

// File: rtl/lut_table_mem.sv
// Shared neuron truth-table store with one registered read port. With LUT_PROG_EN
// it is a writable RAM that must be loaded through the write port before use;
// otherwise it is a ROM holding the trained tables.
module lut_table_mem
    import lut_layer_pkg::*;
(
    input  logic              clk,
`ifdef LUT_PROG_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BW-1:0]     wr_data,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BW-1:0]     rd_data
);

`ifdef LUT_PROG_EN
    logic [BW-1:0] mem [1 << ADDR_W];

    // NOTE: the storage array has no reset: it maps onto distributed RAM, and a
    // reset must leave programmed tables intact.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
`else
    always_ff @(posedge clk) begin
        rd_data <= rom_entry(rd_addr);
    end
`endif

endmodule

// File: rtl/lut_layer_sequencer.sv
// Walks the layer one neuron per cycle through a shared truth-table memory and
// assembles the output activation vector. LUT_PROG_EN adds a table write port.
module lut_layer_sequencer
    import lut_layer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*BW-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_NEUR*BW-1:0] out_data,
    output logic                 busy
`ifdef LUT_PROG_EN
    ,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [BW-1:0]        prog_data
`endif
);

    state_t              state;
    logic [NEUR_W-1:0]   cnt;
    logic [NEUR_W-1:0]   rd_neur;
    logic                issue;
    logic                rd_valid;
    logic [N_IN*BW-1:0]  in_reg;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BW-1:0]       rd_data;
    logic                accept;

`ifdef LUT_PROG_EN
    logic mem_we;

    // Programming wins over a simultaneous input vector in IDLE.
    assign mem_we   = prog_we && (state == IDLE);
    assign in_ready = (state == IDLE) && !prog_we;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // NOTE: every always_comb output gets a default before the loop so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        idx = '0;
        for (int k = 0; k < FANIN; k++) begin
            idx[k*BW +: BW] = in_reg[CONN[cnt][k]*BW +: BW];
        end
    end

    assign rd_addr = {cnt, idx};

    lut_table_mem u_table (
        .clk     (clk),
`ifdef LUT_PROG_EN
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
`endif
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, e.g. rd_neur captures cnt before it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            issue     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_neur   <= '0;
            in_reg    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            // The table read lags its address by one cycle; track which neuron it belongs to.
            rd_valid <= issue;
            rd_neur  <= cnt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_reg <= in_data;
                        cnt    <= '0;
                        issue  <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    if (issue) begin
                        if (cnt == LAST_NEUR) begin
                            issue <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (rd_valid) begin
                        out_data[rd_neur*BW +: BW] <= rd_data;
                        if (rd_neur == LAST_NEUR) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
